// File: rtl/twi_arbiter.sv
// Two-port round-robin arbiter that serialises single-byte register transactions onto one TWI master.
// Optional WAIT timeout with m_abort is enabled by defining TWI_ARB_TIMEOUT_EN.
module twi_arbiter #(
  parameter int TIMEOUT   = 50000,
  parameter int TIMEOUT_W = 16
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       req0_valid,
  input  logic       req0_rnw,
  input  logic [6:0] req0_chip_addr,
  input  logic [7:0] req0_reg_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  output logic       req0_done,
  output logic [7:0] req0_rdata,
  output logic       req0_err,

  input  logic       req1_valid,
  input  logic       req1_rnw,
  input  logic [6:0] req1_chip_addr,
  input  logic [7:0] req1_reg_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       req1_done,
  output logic [7:0] req1_rdata,
  output logic       req1_err,

  output logic       m_start,
  output logic       m_rnw,
  output logic [6:0] m_chip_addr,
  output logic [7:0] m_reg_addr,
  output logic [7:0] m_wdata,
  input  logic [7:0] m_rdata,
  input  logic       m_done,
  input  logic       m_nack,
  output logic       m_abort,

  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       last_owner;
  logic       grant_valid;
  logic       grant_port;
  logic       sel_rnw;
  logic [6:0] sel_chip;
  logic [7:0] sel_reg;
  logic [7:0] sel_wdata;
  logic       timed_out;
  logic       finish;
  logic       finish_err;
  logic [7:0] finish_rdata;

  // A counter that cannot reach TIMEOUT-1 would never fire.
  if (2 ** TIMEOUT_W <= TIMEOUT) begin : g_timeout_w_too_small
    $error("twi_arbiter: TIMEOUT_W too narrow for TIMEOUT");
  end

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_port  = (req0_valid && req1_valid) ? ~last_owner : req1_valid;
    sel_rnw     = grant_port ? req1_rnw       : req0_rnw;
    sel_chip    = grant_port ? req1_chip_addr : req0_chip_addr;
    sel_reg     = grant_port ? req1_reg_addr  : req0_reg_addr;
    sel_wdata   = grant_port ? req1_wdata     : req0_wdata;
  end

  // A write or a NACKed/aborted read reports 8'h00 rather than whatever the bus returned.
  always_comb begin
    finish       = (state == WAIT) && (m_done || timed_out);
    finish_err   = m_done ? m_nack : 1'b1;
    finish_rdata = (m_done && !m_nack && m_rnw) ? m_rdata : 8'h00;
  end

`ifdef TWI_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] wait_cnt;

  assign timed_out = (state == WAIT) && !m_done && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      m_abort  <= 1'b0;
    end else begin
      m_abort <= timed_out;
      if (state == ISSUE) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign timed_out = 1'b0;
  assign m_abort   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_owner  <= 1'b1;
      owner       <= 1'b0;
      m_start     <= 1'b0;
      m_rnw       <= 1'b0;
      m_chip_addr <= 7'h00;
      m_reg_addr  <= 8'h00;
      m_wdata     <= 8'h00;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      req0_rdata  <= 8'h00;
      req1_rdata  <= 8'h00;
      req0_err    <= 1'b0;
      req1_err    <= 1'b0;
    end else begin
      m_start    <= 1'b0;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      req0_done  <= 1'b0;
      req1_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner       <= grant_port;
            m_rnw       <= sel_rnw;
            m_chip_addr <= sel_chip;
            m_reg_addr  <= sel_reg;
            m_wdata     <= sel_wdata;
            m_start     <= 1'b1;
            req0_ready  <= ~grant_port;
            req1_ready  <= grant_port;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (finish) begin
            state <= RESP;
            if (owner) begin
              req1_done  <= 1'b1;
              req1_rdata <= finish_rdata;
              req1_err   <= finish_err;
            end else begin
              req0_done  <= 1'b1;
              req0_rdata <= finish_rdata;
              req0_err   <= finish_err;
            end
          end
        end
        RESP: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
